coplogic_mc: RTL and testbench
==============================

# coplogic_mc

Multi-coprocessor interface logic for the 32-bit core. Decodes COPz/LWCz/SWCz instructions for up to four coprocessors. Tracks coprocessor register writes through the E/M/W pipeline and forwards write-back data to dependent reads. Unlike the single-coprocessor generation, it interlocks on read-after-write distance 1 and on per-coprocessor busy, via a stall request to the core.

## Interface
Parameters:
- NCOP, 2, number of coprocessors served (1..4); coprocessor z is valid when z < NCOP
- DW, 32, coprocessor data width
- AW, 5, coprocessor register address width

Ports:
- SYSCLK  in  1  system clock
- RESET_D1_R  in  1  synchronous reset, active-high
- INSTSF  in  32  S-stage instruction
- INSTM32_S_R_N  in  1  low = INSTSF valid 32-bit instruction
- RHOLD  in  1  global pipeline hold
- DLOAD  in  1  load data returning; forces CWRDATA_R capture
- EXCEPTION  in  1  kill in-flight coprocessor writes
- CBUSY  in  NCOP  coprocessor z cannot accept an access this cycle
- CONDINN  in  NCOP  coprocessor condition inputs (active-low)
- CPCONDN_R  out  NCOP  registered CONDINN
- CSTALL  out  1  hold S stage; block inserts E bubble
- CPUNUSABLE_S  out  1  coprocessor instruction with z >= NCOP (combinational)
- CRDADDR  out  AW  register-file read address
- CRDGEN / CRDCON  out  NCOP  one-hot general/control read strobes
- CRDDATA  in  NCOP*DW  read data, coprocessor z at [z*DW +: DW]
- CWRADDR_R  out  AW  write-back address
- CWRGEN_R / CWRCON_R  out  NCOP  one-hot W-stage write strobes
- CWRDATA_R  out  DW  write-back data
- CMEMOPM_R  out  1  M-stage LWCz/SWCz
- CDRIVERM_R  out  1  block drives data bus in M
- CIDBUSINM  in  DW  core data bus
- CRDDATAM_R  out  DW  M-stage read data

## Operation
- Decode: opcode INSTSF[31:26].
  - 0100zz = COPz. INSTSF[25:21] selects MF=00000, CF=00010, MT=00100, CT=00110; any other value is a no-op.
  - 1100zz = LWCz: memop, general write, address INSTSF[20:16].
  - 1110zz = SWCz: memop, general read, driver, address INSTSF[20:16].
  - MF/CF read and MT/CT write use INSTSF[15:11].
  - Decode is gated by !INSTM32_S_R_N. If z >= NCOP, all strobes stay 0 and CPUNUSABLE_S = 1.
- Write tag per stage (E,M,W): valid, cop, class (gen/con), addr.
- Forward: an S read matching the M-stage tag (valid, same cop, class, addr) sets fwd_E. CRDDATAM_R then captures CWRDATA_R instead of CRDDATA. The read strobe is suppressed for that access.
- Interlock: CSTALL = S read matching the E-stage tag, OR CBUSY[z] for a decoded access. While CSTALL is asserted:
  - all read strobes are 0;
  - E receives a bubble (all E tags and flags 0);
  - M and W advance normally.
- Exception: when EXCEPTION is high and RHOLD is low, valid bits of E/M/W tags and fwd_E are cleared at the edge. Addresses still shift.
- RHOLD high freezes all pipeline registers except CPCONDN_R and CWRDATA_R. CSTALL is still computed combinationally.
- CWRDATA_R <= CIDBUSINM when DLOAD or !RHOLD, else hold.
- CRDDATAM_R <= fwd_E ? CWRDATA_R : CRDDATA[cop_E].

## Timing
- Read strobes, CRDADDR, CSTALL and CPUNUSABLE_S are combinational from S inputs and registered tags.
- Read data appears on CRDDATAM_R one edge after the E cycle.
- Write strobe reaches CWR*_R three edges after S (S->E->M->W).
- Reset: all registered outputs and tags are 0, CWRDATA_R/CRDDATAM_R are 0, CPCONDN_R is 0. With no instruction, all combinational outputs are 0.
- Reset while stalled: the stall clears the next cycle, since tags are 0.
- Simultaneous EXCEPTION and CSTALL: the bubble is inserted and the kill is applied. A killed tag cannot cause a stall or forward in the next cycle.
- Simultaneous M match and E match: the E match wins (stall). After the stall the instruction forwards from M.

## Structure
- Package coplogic_pkg holds:
  - opcode constants COP/LWC/SWC;
  - rs codes MF/CF/MT/CT;
  - the write-tag struct (valid, cop, con, addr).
- Sub-module coplogic_mc_decode: combinational instruction decode producing read/write intents, cop index, address and unusable flag.

## Test plan
- MT cop1 gen r3 (data 0xDEADBEEF), then 2 independent instructions, then MF cop1 r3 -> MF reads from the register file, CRDGEN=0b10, CRDADDR=3.
- MT cop0 r7 immediately followed by MF cop0 r7 -> CSTALL for 1 cycle. Next cycle forwards: CRDGEN=0, CRDDATAM_R=0xDEADBEEF.
- MT cop0 con r7 followed by MF cop0 gen r7 (class mismatch) and MF cop1 r7 (cop mismatch) -> no stall, no forward.
- CBUSY[1] held 3 cycles with SWC1 in S -> CSTALL high 3 cycles, then CMEMOPM_R=1 and CDRIVERM_R=1 two edges after release.
- LWC0 in E, EXCEPTION pulse with RHOLD=0 -> CWRGEN_R never asserts. A following MF does not stall.
- NCOP=2, COP3 MF -> CPUNUSABLE_S=1, all strobes 0. RESET_D1_R mid-stream -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/coplogic_pkg.sv
// Shared constants and types for the multi-coprocessor interface logic:
// opcode/rs encodings, the per-stage write tag and the S-stage decode record.
package coplogic_pkg;

  localparam int REG_AW = 5;

  localparam logic [3:0] OP_COP = 4'b0100;
  localparam logic [3:0] OP_LWC = 4'b1100;
  localparam logic [3:0] OP_SWC = 4'b1110;

  localparam logic [4:0] RS_MF = 5'b00000;
  localparam logic [4:0] RS_CF = 5'b00010;
  localparam logic [4:0] RS_MT = 5'b00100;
  localparam logic [4:0] RS_CT = 5'b00110;

  typedef struct packed {
    logic              valid;
    logic [1:0]        cop;
    logic              con;
    logic [REG_AW-1:0] addr;
  } wtag_t;

  // A COPz instruction is either a read or a write, so one class bit covers both.
  typedef struct packed {
    logic              rd;
    logic              wr;
    logic              con;
    logic              memop;
    logic              driver;
    logic              unusable;
    logic [1:0]        cop;
    logic [REG_AW-1:0] addr;
  } dec_t;

  function automatic logic tag_hit(wtag_t t, logic [1:0] cop, logic con,
                                   logic [REG_AW-1:0] addr);
    return t.valid && (t.cop == cop) && (t.con == con) && (t.addr == addr);
  endfunction

  function automatic wtag_t kill_tag(wtag_t t, logic kill);
    wtag_t r;
    r       = t;
    r.valid = t.valid && !kill;
    return r;
  endfunction

endpackage

// File: rtl/coplogic_mc_if.sv
// Core-side and coprocessor-side signal bundle of coplogic_mc.
// master = the interface block, slave = the core/coprocessor environment.
interface coplogic_mc_if #(
  parameter int NCOP = 2,
  parameter int DW   = 32,
  parameter int AW   = 5
);
  logic [31:0]      INSTSF;
  logic             INSTM32_S_R_N;
  logic             RHOLD;
  logic             DLOAD;
  logic             EXCEPTION;
  logic [NCOP-1:0]  CBUSY;
  logic [NCOP-1:0]  CONDINN;
  logic [NCOP-1:0]  CPCONDN_R;
  logic             CSTALL;
  logic             CPUNUSABLE_S;
  logic [AW-1:0]    CRDADDR;
  logic [NCOP-1:0]  CRDGEN;
  logic [NCOP-1:0]  CRDCON;
  logic [NCOP*DW-1:0] CRDDATA;
  logic [AW-1:0]    CWRADDR_R;
  logic [NCOP-1:0]  CWRGEN_R;
  logic [NCOP-1:0]  CWRCON_R;
  logic [DW-1:0]    CWRDATA_R;
  logic             CMEMOPM_R;
  logic             CDRIVERM_R;
  logic [DW-1:0]    CIDBUSINM;
  logic [DW-1:0]    CRDDATAM_R;

  modport master (
    input  INSTSF, INSTM32_S_R_N, RHOLD, DLOAD, EXCEPTION, CBUSY, CONDINN,
           CRDDATA, CIDBUSINM,
    output CPCONDN_R, CSTALL, CPUNUSABLE_S, CRDADDR, CRDGEN, CRDCON,
           CWRADDR_R, CWRGEN_R, CWRCON_R, CWRDATA_R, CMEMOPM_R, CDRIVERM_R,
           CRDDATAM_R
  );

  modport slave (
    output INSTSF, INSTM32_S_R_N, RHOLD, DLOAD, EXCEPTION, CBUSY, CONDINN,
           CRDDATA, CIDBUSINM,
    input  CPCONDN_R, CSTALL, CPUNUSABLE_S, CRDADDR, CRDGEN, CRDCON,
           CWRADDR_R, CWRGEN_R, CWRCON_R, CWRDATA_R, CMEMOPM_R, CDRIVERM_R,
           CRDDATAM_R
  );
endinterface

// File: rtl/coplogic_mc_decode.sv
// Combinational S-stage decode of COPz/LWCz/SWCz into read/write intents,
// coprocessor index, register address and the unusable-coprocessor flag.
module coplogic_mc_decode
  import coplogic_pkg::*;
#(
  parameter int NCOP = 2
) (
  input  logic [31:0] inst,
  input  logic        inst_vld,
  output dec_t        dec
);

  logic is_cop;
  logic is_lwc;
  logic is_swc;
  logic legal;
  logic unused_bits;

  assign unused_bits = ^inst[10:0];

  always_comb begin
    dec    = '0;
    is_cop = inst_vld && (inst[31:28] == OP_COP);
    is_lwc = inst_vld && (inst[31:28] == OP_LWC);
    is_swc = inst_vld && (inst[31:28] == OP_SWC);
    legal  = int'(inst[27:26]) < NCOP;

    dec.unusable = (is_cop || is_lwc || is_swc) && !legal;

    if (legal && (is_cop || is_lwc || is_swc)) begin
      dec.cop = inst[27:26];
      if (is_cop) begin
        dec.addr = inst[15:11];
        case (inst[25:21])
          RS_MF: dec.rd = 1'b1;
          RS_CF: begin
            dec.rd  = 1'b1;
            dec.con = 1'b1;
          end
          RS_MT: dec.wr = 1'b1;
          RS_CT: begin
            dec.wr  = 1'b1;
            dec.con = 1'b1;
          end
          default: ;
        endcase
      end else if (is_lwc) begin
        dec.addr  = inst[20:16];
        dec.memop = 1'b1;
        dec.wr    = 1'b1;
      end else begin
        dec.addr   = inst[20:16];
        dec.memop  = 1'b1;
        dec.rd     = 1'b1;
        dec.driver = 1'b1;
      end
    end
  end

endmodule

// File: rtl/coplogic_mc.sv
// Multi-coprocessor interface logic: decode, E/M/W write tracking, M-stage
// forwarding, and interlock on distance-1 RAW hazards and coprocessor busy.
module coplogic_mc
  import coplogic_pkg::*;
#(
  parameter int NCOP = 2,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic          SYSCLK,
  input  logic          RESET_D1_R,
  coplogic_mc_if.master bus
);

  dec_t            dec;
  wtag_t           tag_new;
  wtag_t           tag_p0;
  wtag_t           tag_p1;
  wtag_t           tag_p2;
  logic            fwd_p0;
  logic [1:0]      cop_p0;
  logic            memop_p0;
  logic            memop_p1;
  logic            driver_p0;
  logic            driver_p1;
  logic [DW-1:0]   rd_data_p1;
  logic [DW-1:0]   wr_data;
  logic [NCOP-1:0] cond_r;
  logic [DW-1:0]   rd_sel;
  logic            hit_e;
  logic            hit_m;
  logic            busy_hit;
  logic            stall;
  logic            rd_go;
  logic [NCOP-1:0] rd_gen;
  logic [NCOP-1:0] rd_con;
  logic [AW-1:0]   rd_addr;
  logic [NCOP-1:0] wr_gen;
  logic [NCOP-1:0] wr_con;

  coplogic_mc_decode #(.NCOP(NCOP)) u_decode (
    .inst     (bus.INSTSF),
    .inst_vld (!bus.INSTM32_S_R_N),
    .dec      (dec)
  );

  // S stage: hazard detection and read strobes
  always_comb begin
    hit_e    = dec.rd && tag_hit(tag_p0, dec.cop, dec.con, dec.addr);
    hit_m    = dec.rd && tag_hit(tag_p1, dec.cop, dec.con, dec.addr);
    busy_hit = 1'b0;
    for (int i = 0; i < NCOP; i++) begin
      if ((dec.rd || dec.wr) && (dec.cop == 2'(i)) && bus.CBUSY[i]) busy_hit = 1'b1;
    end
    // An E-stage hit outranks an M-stage hit; the retry then forwards from M.
    stall   = hit_e || busy_hit;
    rd_go   = dec.rd && !stall && !hit_m;
    rd_gen  = '0;
    rd_con  = '0;
    rd_addr = '0;
    for (int i = 0; i < NCOP; i++) begin
      if (rd_go && (dec.cop == 2'(i))) begin
        rd_gen[i] = !dec.con;
        rd_con[i] = dec.con;
      end
    end
    if (rd_go) rd_addr = AW'(dec.addr);

    tag_new = '0;
    if (!stall) begin
      tag_new.valid = dec.wr;
      tag_new.cop   = dec.cop;
      tag_new.con   = dec.con;
      tag_new.addr  = dec.addr;
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NCOP; i++) begin
      if (cop_p0 == 2'(i)) rd_sel = bus.CRDDATA[i*DW +: DW];
    end
    wr_gen = '0;
    wr_con = '0;
    for (int i = 0; i < NCOP; i++) begin
      if (tag_p2.valid && (tag_p2.cop == 2'(i))) begin
        wr_gen[i] = !tag_p2.con;
        wr_con[i] = tag_p2.con;
      end
    end
  end

  // S->E, E->M, M->W pipeline; a hold freezes every stage
  always_ff @(posedge SYSCLK) begin
    if (RESET_D1_R) begin
      tag_p0     <= '0;
      tag_p1     <= '0;
      tag_p2     <= '0;
      fwd_p0     <= 1'b0;
      cop_p0     <= '0;
      memop_p0   <= 1'b0;
      memop_p1   <= 1'b0;
      driver_p0  <= 1'b0;
      driver_p1  <= 1'b0;
      rd_data_p1 <= '0;
    end else if (!bus.RHOLD) begin
      tag_p0     <= kill_tag(tag_new, bus.EXCEPTION);
      tag_p1     <= kill_tag(tag_p0, bus.EXCEPTION);
      tag_p2     <= kill_tag(tag_p1, bus.EXCEPTION);
      fwd_p0     <= hit_m && !stall && !bus.EXCEPTION;
      cop_p0     <= stall ? 2'b00 : dec.cop;
      memop_p0   <= dec.memop && !stall;
      driver_p0  <= dec.driver && !stall;
      memop_p1   <= memop_p0;
      driver_p1  <= driver_p0;
      rd_data_p1 <= fwd_p0 ? wr_data : rd_sel;
    end
  end

  // Condition inputs and load/write-back data ignore the pipeline hold
  always_ff @(posedge SYSCLK) begin
    if (RESET_D1_R) begin
      cond_r  <= '0;
      wr_data <= '0;
    end else begin
      cond_r <= bus.CONDINN;
      if (bus.DLOAD || !bus.RHOLD) wr_data <= bus.CIDBUSINM;
    end
  end

  assign bus.CSTALL       = stall;
  assign bus.CPUNUSABLE_S = dec.unusable;
  assign bus.CRDGEN       = rd_gen;
  assign bus.CRDCON       = rd_con;
  assign bus.CRDADDR      = rd_addr;
  assign bus.CWRGEN_R     = wr_gen;
  assign bus.CWRCON_R     = wr_con;
  assign bus.CWRADDR_R    = AW'(tag_p2.addr);
  assign bus.CWRDATA_R    = wr_data;
  assign bus.CMEMOPM_R    = memop_p1;
  assign bus.CDRIVERM_R   = driver_p1;
  assign bus.CRDDATAM_R   = rd_data_p1;
  assign bus.CPCONDN_R    = cond_r;

endmodule

// File: tb/tb_coplogic_mc.sv
// Directed bench for coplogic_mc (NCOP=2): decode, forwarding, interlocks,
// exception kill, hold/DLOAD, unusable coprocessor and mid-stream reset.
module tb_coplogic_mc;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  coplogic_mc_if #(.NCOP(2), .DW(32), .AW(5)) bus ();

  coplogic_mc #(.NCOP(2), .DW(32), .AW(5)) dut (
    .SYSCLK     (clk),
    .RESET_D1_R (rst),
    .bus        (bus)
  );

  localparam logic [4:0] MF = 5'h00, CF = 5'h02, MT = 5'h04, CT = 5'h06;

  function automatic logic [31:0] copi(logic [4:0] rs, logic [1:0] z, logic [4:0] rd);
    return {4'b0100, z, rs, 5'd0, rd, 11'd0};
  endfunction

  function automatic logic [31:0] memi(logic [3:0] opc, logic [1:0] z, logic [4:0] rt);
    return {opc, z, 5'd0, rt, 16'd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] i);
    bus.INSTSF        = i;
    bus.INSTM32_S_R_N = 1'b0;
  endtask

  task automatic idle();
    bus.INSTSF        = 32'h0;
    bus.INSTM32_S_R_N = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus.RHOLD     = 1'b0;
    bus.DLOAD     = 1'b0;
    bus.EXCEPTION = 1'b0;
    bus.CBUSY     = 2'b00;
    bus.CONDINN   = 2'b11;
    bus.CRDDATA   = {32'h1111_1111, 32'h0000_0C0C};
    bus.CIDBUSINM = 32'h0;
    step();
    step();
    chk("rst_cpcond", 32'(bus.CPCONDN_R), 32'h0);
    chk("rst_rddatam", bus.CRDDATAM_R, 32'h0);
    chk("rst_wrdata", bus.CWRDATA_R, 32'h0);
    chk("rst_wrgen", 32'(bus.CWRGEN_R), 32'h0);
    chk("rst_memop", 32'(bus.CMEMOPM_R), 32'h0);
    chk("rst_stall", 32'(bus.CSTALL), 32'h0);
    chk("rst_rdgen", 32'(bus.CRDGEN), 32'h0);
    chk("rst_unusable", 32'(bus.CPUNUSABLE_S), 32'h0);
    rst = 1'b0;
    step();
    chk("cpcond_follow", 32'(bus.CPCONDN_R), 32'h3);

    // MT cop1 r3, two unrelated instructions, then MF cop1 r3 from the register file
    issue(copi(MT, 2'd1, 5'd3));
    #2 chk("t1_mt_nostall", 32'(bus.CSTALL), 32'h0);
    step(); issue(32'h2402_0001);
    step(); issue(32'h0000_0020); bus.CIDBUSINM = 32'hDEAD_BEEF;
    step(); bus.CIDBUSINM = 32'h0; issue(copi(MF, 2'd1, 5'd3));
    #2;
    chk("t1_wrgen", 32'(bus.CWRGEN_R), 32'h2);
    chk("t1_wraddr", 32'(bus.CWRADDR_R), 32'h3);
    chk("t1_wrdata", bus.CWRDATA_R, 32'hDEAD_BEEF);
    chk("t1_rdgen", 32'(bus.CRDGEN), 32'h2);
    chk("t1_rdaddr", 32'(bus.CRDADDR), 32'h3);
    chk("t1_stall", 32'(bus.CSTALL), 32'h0);
    step(); idle();
    step();
    chk("t1_rddatam", bus.CRDDATAM_R, 32'h1111_1111);

    // MT cop0 r7 then MF cop0 r7: one stall cycle, then forward
    issue(copi(MT, 2'd0, 5'd7));
    step(); issue(copi(MF, 2'd0, 5'd7));
    #2;
    chk("t2_stall", 32'(bus.CSTALL), 32'h1);
    chk("t2_stall_rdgen", 32'(bus.CRDGEN), 32'h0);
    step(); bus.CIDBUSINM = 32'hDEAD_BEEF;
    #2;
    chk("t2_unstall", 32'(bus.CSTALL), 32'h0);
    chk("t2_fwd_rdgen", 32'(bus.CRDGEN), 32'h0);
    step(); bus.CIDBUSINM = 32'h0; idle();
    #2;
    chk("t2_wrgen", 32'(bus.CWRGEN_R), 32'h1);
    chk("t2_wraddr", 32'(bus.CWRADDR_R), 32'h7);
    step();
    chk("t2_fwd_data", bus.CRDDATAM_R, 32'hDEAD_BEEF);

    // CT cop0 r7, then class-mismatch and cop-mismatch reads
    issue(copi(CT, 2'd0, 5'd7));
    step(); issue(copi(MF, 2'd0, 5'd7));
    #2;
    chk("t3_class_stall", 32'(bus.CSTALL), 32'h0);
    chk("t3_class_rdgen", 32'(bus.CRDGEN), 32'h1);
    chk("t3_class_rdaddr", 32'(bus.CRDADDR), 32'h7);
    step(); issue(copi(MF, 2'd1, 5'd7));
    #2;
    chk("t3_cop_stall", 32'(bus.CSTALL), 32'h0);
    chk("t3_cop_rdgen", 32'(bus.CRDGEN), 32'h2);
    step(); idle();
    #2;
    chk("t3_wrcon", 32'(bus.CWRCON_R), 32'h1);
    chk("t3_wrgen", 32'(bus.CWRGEN_R), 32'h0);
    chk("t3_rd_cop0", bus.CRDDATAM_R, 32'h0000_0C0C);
    step();
    chk("t3_rd_cop1", bus.CRDDATAM_R, 32'h1111_1111);

    // SWC1 r5 held off by CBUSY[1] for three cycles
    bus.CBUSY = 2'b10; issue(memi(4'b1110, 2'd1, 5'd5));
    #2;
    chk("t4_busy_c1", 32'(bus.CSTALL), 32'h1);
    chk("t4_busy_rdgen", 32'(bus.CRDGEN), 32'h0);
    step(); #1 chk("t4_busy_c2", 32'(bus.CSTALL), 32'h1);
    step(); #1 chk("t4_busy_c3", 32'(bus.CSTALL), 32'h1);
    step(); bus.CBUSY = 2'b01;
    #2;
    chk("t4_release", 32'(bus.CSTALL), 32'h0);
    chk("t4_rdgen", 32'(bus.CRDGEN), 32'h2);
    chk("t4_rdaddr", 32'(bus.CRDADDR), 32'h5);
    chk("t4_memop_bubble", 32'(bus.CMEMOPM_R), 32'h0);
    step(); bus.CBUSY = 2'b00; idle();
    #2 chk("t4_memop_e", 32'(bus.CMEMOPM_R), 32'h0);
    step();
    chk("t4_memop_m", 32'(bus.CMEMOPM_R), 32'h1);
    chk("t4_driver_m", 32'(bus.CDRIVERM_R), 32'h1);
    step();
    chk("t4_memop_done", 32'(bus.CMEMOPM_R), 32'h0);

    // LWC0 r9 killed in E while a dependent MF is stalled
    issue(memi(4'b1100, 2'd0, 5'd9));
    step(); issue(copi(MF, 2'd0, 5'd9)); bus.EXCEPTION = 1'b1;
    #2 chk("t5_exc_stall", 32'(bus.CSTALL), 32'h1);
    step(); bus.EXCEPTION = 1'b0;
    #2;
    chk("t5_killed_nostall", 32'(bus.CSTALL), 32'h0);
    chk("t5_killed_nofwd", 32'(bus.CRDGEN), 32'h1);
    step(); idle();
    #2 chk("t5_wrgen_killed", 32'(bus.CWRGEN_R), 32'h0);
    step();

    // Hold freezes the pipeline; DLOAD and CONDINN still captured
    issue(copi(MT, 2'd1, 5'd2));
    step(); issue(copi(MF, 2'd1, 5'd2));
    bus.RHOLD = 1'b1; bus.CONDINN = 2'b01; bus.DLOAD = 1'b1; bus.CIDBUSINM = 32'h1234_5678;
    #2 chk("t6_hold_stall", 32'(bus.CSTALL), 32'h1);
    step(); bus.DLOAD = 1'b0; bus.CIDBUSINM = 32'h0;
    #2;
    chk("t6_hold_cond", 32'(bus.CPCONDN_R), 32'h1);
    chk("t6_dload", bus.CWRDATA_R, 32'h1234_5678);
    chk("t6_hold_stall2", 32'(bus.CSTALL), 32'h1);
    chk("t6_hold_wrgen", 32'(bus.CWRGEN_R), 32'h0);
    step();
    #2;
    chk("t6_hold_wrdata", bus.CWRDATA_R, 32'h1234_5678);
    chk("t6_hold_stall3", 32'(bus.CSTALL), 32'h1);
    bus.RHOLD = 1'b0;
    step(); bus.CIDBUSINM = 32'hCAFE_F00D;
    #2;
    chk("t6_fwd_nostall", 32'(bus.CSTALL), 32'h0);
    chk("t6_fwd_rdgen", 32'(bus.CRDGEN), 32'h0);
    step(); bus.CIDBUSINM = 32'h0; idle();
    #2;
    chk("t6_wrgen", 32'(bus.CWRGEN_R), 32'h2);
    chk("t6_wraddr", 32'(bus.CWRADDR_R), 32'h2);
    step();
    chk("t6_fwd_data", bus.CRDDATAM_R, 32'hCAFE_F00D);

    // Unusable coprocessors with NCOP=2
    issue(copi(MF, 2'd3, 5'd4));
    #2;
    chk("t7_cop3_unusable", 32'(bus.CPUNUSABLE_S), 32'h1);
    chk("t7_cop3_rdgen", 32'(bus.CRDGEN), 32'h0);
    chk("t7_cop3_rdcon", 32'(bus.CRDCON), 32'h0);
    chk("t7_cop3_stall", 32'(bus.CSTALL), 32'h0);
    issue(memi(4'b1100, 2'd2, 5'd4));
    #2 chk("t7_lwc2_unusable", 32'(bus.CPUNUSABLE_S), 32'h1);
    bus.INSTM32_S_R_N = 1'b1;
    #2 chk("t7_invalid_inst", 32'(bus.CPUNUSABLE_S), 32'h0);
    issue(copi(CF, 2'd1, 5'd4));
    #2;
    chk("t7_cf1_usable", 32'(bus.CPUNUSABLE_S), 32'h0);
    chk("t7_cf1_rdcon", 32'(bus.CRDCON), 32'h2);
    chk("t7_cf1_rdgen", 32'(bus.CRDGEN), 32'h0);

    // Reset while stalled
    bus.CIDBUSINM = 32'hDEAD_BEEF; issue(copi(MT, 2'd0, 5'd4));
    step(); issue(copi(MF, 2'd0, 5'd4));
    #2 chk("t8_pre_stall", 32'(bus.CSTALL), 32'h1);
    rst = 1'b1;
    step();
    #2;
    chk("t8_stall_clear", 32'(bus.CSTALL), 32'h0);
    chk("t8_wrgen", 32'(bus.CWRGEN_R), 32'h0);
    chk("t8_wraddr", 32'(bus.CWRADDR_R), 32'h0);
    chk("t8_wrdata", bus.CWRDATA_R, 32'h0);
    chk("t8_rddatam", bus.CRDDATAM_R, 32'h0);
    chk("t8_cpcond", 32'(bus.CPCONDN_R), 32'h0);
    chk("t8_memop", 32'(bus.CMEMOPM_R), 32'h0);
    rst = 1'b0;
    idle();
    bus.CIDBUSINM = 32'h0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
